// File: rtl/adc_byte_packer_pkg.sv
// Shared definitions for the ADC byte packer: error-bit indices, queue depth and pair states.
package adc_byte_packer_pkg;

    localparam int unsigned ERR_UNDERFLOW = 0;
    localparam int unsigned ERR_OVERFLOW  = 1;
    localparam int unsigned ERR_MODESPLIT = 2;

    localparam int unsigned QUEUE_DEPTH = 4;

    typedef enum logic {
        PAIR0 = 1'b0,
        PAIR1 = 1'b1
    } pair_state_e;

endpackage

// File: rtl/adc_byte_packer_byte_queue4.sv
// Four-entry first-word-fall-through byte queue with a 0/1/2-byte push and a 1-byte pop.
module byte_queue4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] push_n,
    input  logic [7:0] push_b0,
    input  logic [7:0] push_b1,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic [2:0] cnt
);

    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] base;
    logic       pop_ok;

    // Entry 0 is always the head; a pop shifts down, pushes land just past the survivors.
    always_comb begin
        mem_d  = mem_q;
        pop_ok = pop && (cnt_q != 3'd0);
        if (pop_ok) begin
            for (int i = 0; i < 3; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        base = cnt_q - {2'b00, pop_ok};
        if (push_n != 2'd0) begin
            mem_d[base[1:0]] = push_b0;
        end
        if (push_n == 2'd2) begin
            mem_d[base[1:0] + 2'd1] = push_b1;
        end
        cnt_d = cnt_q + {1'b0, push_n} - {2'b00, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign head  = mem_q[0];
    assign empty = (cnt_q == 3'd0);
    assign cnt   = cnt_q;

endmodule

// File: rtl/adc_byte_packer.sv
// Packs 12-bit ADC samples into bytes (3 bytes per 2 samples, or 1 byte per sample in low-res
// mode) and provides the byte-FIFO view, sticky error flags and read counters.
module adc_byte_packer
    import adc_byte_packer_pkg::*;
(
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic [11:0] sample_data,
    input  logic        sample_empty,
    output logic        sample_rd_en,
    input  logic        sample_overflow,
    input  logic        flush,
    input  logic        low_res,
    input  logic        low_res_lsb,
    input  logic        fifo_rd_en,
    input  logic        clear_fifo_errors,
    output logic        fifo_empty,
    output logic [7:0]  fifo_data,
    output logic [7:0]  fifo_error_stat,
    output logic [31:0] fifo_read_count,
    output logic [31:0] fifo_read_count_error_freeze
);

    pair_state_e state_q, state_d;
    logic        mode_q;
    logic [3:0]  nib_q;
    logic        flush_pend_q;
    logic [2:0]  err_q, err_set;
    logic [31:0] count_q, freeze_q;

    logic [2:0]  queue_cnt;
    logic [2:0]  free;
    logic [1:0]  push_n;
    logic [7:0]  push_b0, push_b1;
    logic        flush_fire;
    logic        pop;

    byte_queue4 u_queue (
        .clk     (clk_usb),
        .rst     (reset_i),
        .push_n  (push_n),
        .push_b0 (push_b0),
        .push_b1 (push_b1),
        .pop     (pop),
        .head    (fifo_data),
        .empty   (fifo_empty),
        .cnt     (queue_cnt)
    );

    // Free space is taken before the same-cycle pop so a push never relies on it.
    assign free = 3'(QUEUE_DEPTH) - queue_cnt;
    assign pop  = fifo_rd_en && !fifo_empty;

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state_q <= PAIR0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PAIR0: if (sample_rd_en && !mode_q) state_d = PAIR1;
            PAIR1: if (push_n == 2'd2) state_d = PAIR0;
            default: state_d = PAIR0;
        endcase
    end

    always_comb begin
        sample_rd_en = 1'b0;
        push_n       = 2'd0;
        push_b0      = 8'h00;
        push_b1      = 8'h00;
        flush_fire   = 1'b0;
        unique case (state_q)
            PAIR0: begin
                if (!sample_empty && free >= 3'd1 && !reset_i) begin
                    sample_rd_en = 1'b1;
                    push_n       = 2'd1;
                    push_b0      = (mode_q && low_res_lsb) ? sample_data[7:0] : sample_data[11:4];
                end
            end
            PAIR1: begin
                if (!sample_empty && free >= 3'd2 && !reset_i) begin
                    sample_rd_en = 1'b1;
                    push_n       = 2'd2;
                    push_b0      = {nib_q, sample_data[11:8]};
                    push_b1      = sample_data[7:0];
                end else if (sample_empty && free >= 3'd2 && flush_pend_q) begin
                    push_n     = 2'd2;
                    push_b0    = {nib_q, 4'h0};
                    flush_fire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        err_set                = 3'b000;
        err_set[ERR_UNDERFLOW] = fifo_rd_en && fifo_empty;
        err_set[ERR_OVERFLOW]  = sample_overflow;
        err_set[ERR_MODESPLIT] = (state_q == PAIR1) && (low_res != mode_q);
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            mode_q       <= 1'b0;
            nib_q        <= 4'h0;
            flush_pend_q <= 1'b0;
            err_q        <= 3'b000;
            count_q      <= 32'd0;
            freeze_q     <= 32'd0;
        end else begin
            if (state_q == PAIR0) begin
                mode_q <= low_res;
            end
            if (state_q == PAIR0 && sample_rd_en && !mode_q) begin
                nib_q <= sample_data[3:0];
            end
            if (flush) begin
                flush_pend_q <= 1'b1;
            end else if (clear_fifo_errors || flush_fire || state_q == PAIR0) begin
                flush_pend_q <= 1'b0;
            end
            // A new error landing on a clear still wins and re-captures the freeze value.
            err_q   <= (clear_fifo_errors ? 3'b000 : err_q) | err_set;
            count_q <= clear_fifo_errors ? 32'd0 : count_q + {31'd0, pop};
            if (err_set != 3'b000 && (err_q == 3'b000 || clear_fifo_errors)) begin
                freeze_q <= count_q;
            end else if (clear_fifo_errors) begin
                freeze_q <= 32'd0;
            end
        end
    end

    assign fifo_error_stat              = {5'b00000, err_q};
    assign fifo_read_count              = count_q;
    assign fifo_read_count_error_freeze = freeze_q;

endmodule

// File: tb/tb_adc_byte_packer.sv
// Self-checking bench: a queue-based sample source and an expected byte stream built from the
// packing rules, compared against every byte the reader pops.
module tb_adc_byte_packer;
    import adc_byte_packer_pkg::*;

    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic [11:0] sample_data;
    logic        sample_empty;
    logic        sample_rd_en;
    logic        sample_overflow;
    logic        flush;
    logic        low_res;
    logic        low_res_lsb;
    logic        fifo_rd_en;
    logic        clear_fifo_errors;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic [7:0]  fifo_error_stat;
    logic [31:0] fifo_read_count;
    logic [31:0] fifo_read_count_error_freeze;

    adc_byte_packer dut (
        .clk_usb                      (clk_usb),
        .reset_i                      (reset_i),
        .sample_data                  (sample_data),
        .sample_empty                 (sample_empty),
        .sample_rd_en                 (sample_rd_en),
        .sample_overflow              (sample_overflow),
        .flush                        (flush),
        .low_res                      (low_res),
        .low_res_lsb                  (low_res_lsb),
        .fifo_rd_en                   (fifo_rd_en),
        .clear_fifo_errors            (clear_fifo_errors),
        .fifo_empty                   (fifo_empty),
        .fifo_data                    (fifo_data),
        .fifo_error_stat              (fifo_error_stat),
        .fifo_read_count              (fifo_read_count),
        .fifo_read_count_error_freeze (fifo_read_count_error_freeze)
    );

    always #5 clk_usb = ~clk_usb;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [11:0] src_q [$];
    logic [7:0]  exp_q [$];
    logic [31:0] model_count;
    logic [31:0] freeze_exp;
    logic        reader;
    logic        force_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        sample_empty = (src_q.size() == 0);
        sample_data  = sample_empty ? 12'h000 : src_q[0];
        fifo_rd_en   = (reader && !fifo_empty) || force_rd;
    endtask

    // One clock: present inputs, consume a popped byte against the model, then advance.
    task automatic tick();
        logic popped;
        drive_inputs();
        #1;
        if (fifo_rd_en && !fifo_empty) begin
            if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
            else check("byte", {24'h0, fifo_data}, {24'h0, exp_q.pop_front()});
            model_count++;
        end
        popped = sample_rd_en && !sample_empty;
        @(posedge clk_usb);
        if (popped) void'(src_q.pop_front());
        @(negedge clk_usb);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check(tag, exp_q.size() + src_q.size(), 0);
    endtask

    task automatic add12(input logic [11:0] s0, input logic [11:0] s1);
        src_q.push_back(s0);
        src_q.push_back(s1);
        exp_q.push_back(s0[11:4]);
        exp_q.push_back({s0[3:0], s1[11:8]});
        exp_q.push_back(s1[7:0]);
    endtask

    task automatic add8(input logic [11:0] s, input logic lsb);
        src_q.push_back(s);
        exp_q.push_back(lsb ? s[7:0] : s[11:4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] a, b;
        logic        lsb;
        reset_i = 1'b1; sample_overflow = 1'b0; flush = 1'b0; low_res = 1'b0;
        low_res_lsb = 1'b0; clear_fifo_errors = 1'b0; reader = 1'b0; force_rd = 1'b0;
        model_count = 32'd0;
        drive_inputs();
        repeat (2) @(negedge clk_usb);
        check("rst_empty", fifo_empty, 1);
        check("rst_data", fifo_data, 0);
        check("rst_err", fifo_error_stat, 0);
        check("rst_count", fifo_read_count, 0);
        check("rst_freeze", fifo_read_count_error_freeze, 0);
        check("rst_rd_en", sample_rd_en, 0);
        reset_i = 1'b0;
        idle(2);

        // Full resolution pair with a continuous reader.
        reader = 1'b1;
        src_q.push_back(12'hABC); src_q.push_back(12'h123);
        exp_q.push_back(8'hAB); exp_q.push_back(8'hC1); exp_q.push_back(8'h23);
        drain("drain_12bit");
        check("count_12bit", fifo_read_count, model_count);
        check("err_12bit", fifo_error_stat, 0);

        // Low resolution, both byte selections.
        low_res = 1'b1;
        idle(2);
        low_res_lsb = 1'b0;
        src_q.push_back(12'hABC); src_q.push_back(12'h123);
        exp_q.push_back(8'hAB); exp_q.push_back(8'h12);
        drain("drain_8msb");
        low_res_lsb = 1'b1;
        src_q.push_back(12'hABC); src_q.push_back(12'h123);
        exp_q.push_back(8'hBC); exp_q.push_back(8'h23);
        drain("drain_8lsb");
        check("count_8bit", fifo_read_count, model_count);

        // Odd sample count closed by a flush.
        low_res = 1'b0;
        idle(2);
        src_q.push_back(12'h5A7);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h70); exp_q.push_back(8'h00);
        idle(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("drain_flush");
        idle(2);
        check("flush_state", dut.state_q, PAIR0);

        // No reader: queue fills and the sample side stalls, then drains in order.
        reader = 1'b0;
        for (int k = 0; k < 10; k++) add12(12'($urandom), 12'($urandom));
        idle(30);
        drive_inputs();
        #1;
        check("sat_cnt", dut.queue_cnt, 4);
        check("sat_rd_en", sample_rd_en, 0);
        check("sat_empty", fifo_empty, 0);
        reader = 1'b1;
        drain("drain_sat");
        check("count_sat", fifo_read_count, model_count);

        // Underflow after exactly seven good reads.
        clear_fifo_errors = 1'b1;
        tick();
        clear_fifo_errors = 1'b0;
        model_count = 32'd0;
        low_res = 1'b1;
        lsb = 1'($urandom);
        low_res_lsb = lsb;
        idle(2);
        for (int k = 0; k < 7; k++) add8(12'($urandom), lsb);
        drain("drain_seven");
        check("count_seven", fifo_read_count, model_count);
        freeze_exp = model_count;
        force_rd = 1'b1;
        tick();
        force_rd = 1'b0;
        check("uf_err", fifo_error_stat, 32'h01);
        check("uf_freeze", fifo_read_count_error_freeze, freeze_exp);
        for (int k = 0; k < 3; k++) add8(12'($urandom), lsb);
        drain("drain_after_uf");
        check("uf_count_more", fifo_read_count, model_count);
        check("uf_freeze_hold", fifo_read_count_error_freeze, freeze_exp);
        check("uf_err_hold", fifo_error_stat, 32'h01);
        clear_fifo_errors = 1'b1;
        tick();
        clear_fifo_errors = 1'b0;
        model_count = 32'd0;
        check("clr_err", fifo_error_stat, 0);
        check("clr_count", fifo_read_count, 0);
        check("clr_freeze", fifo_read_count_error_freeze, 0);
        sample_overflow = 1'b1;
        tick();
        sample_overflow = 1'b0;
        check("ovf_err", fifo_error_stat, 32'h02);
        check("ovf_freeze", fifo_read_count_error_freeze, model_count);
        clear_fifo_errors = 1'b1;
        tick();
        clear_fifo_errors = 1'b0;
        model_count = 32'd0;

        // Mode change in the middle of a pair.
        low_res = 1'b0;
        idle(2);
        a = 12'($urandom);
        b = 12'($urandom);
        src_q.push_back(a);
        exp_q.push_back(a[11:4]);
        idle(3);
        freeze_exp = model_count;
        low_res = 1'b1;
        idle(2);
        check("split_err", fifo_error_stat, 32'h04);
        check("split_freeze", fifo_read_count_error_freeze, freeze_exp);
        src_q.push_back(b);
        exp_q.push_back({a[3:0], b[11:8]});
        exp_q.push_back(b[7:0]);
        drain("drain_split");
        idle(2);
        for (int k = 0; k < 3; k++) add8(12'($urandom), lsb);
        drain("drain_after_split");
        check("count_split", fifo_read_count, model_count);

        // Asynchronous reset with half a pair held.
        reader = 1'b0;
        low_res = 1'b0;
        idle(2);
        src_q.push_back(12'($urandom));
        idle(3);
        check("pre_rst_empty", fifo_empty, 0);
        #2 reset_i = 1'b1;
        #1;
        check("async_empty", fifo_empty, 1);
        check("async_data", fifo_data, 0);
        check("async_state", dut.state_q, PAIR0);
        check("async_cnt", dut.queue_cnt, 0);
        src_q.delete();
        exp_q.delete();
        @(negedge clk_usb);
        reset_i = 1'b0;
        model_count = 32'd0;
        idle(2);
        check("post_rst_err", fifo_error_stat, 0);
        check("post_rst_count", fifo_read_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
